// File: rtl/ball_motion_ctrl.sv
// Ball position controller: moves the ball once per video frame during vertical blanking,
// bounces it off the side walls, the top wall and the paddle, and respawns it after a miss.
module ball_motion_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int RADIUS   = 10,
   parameter int SPEED    = 2,
   parameter int START_X  = 320,
   parameter int START_Y  = 240,
   parameter int PADDLE_Y = 450,
   parameter int PADDLE_W = 80
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pTick,
   input  logic [9:0] pixelX,
   input  logic [9:0] pixelY,
   input  logic       start,
   input  logic [9:0] paddleX,
   output logic [9:0] ballX,
   output logic [9:0] ballY,
   output logic       running,
   output logic       frameTick,
   output logic       bounceX,
   output logic       bounceY,
   output logic       paddleHit,
   output logic       missed
);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

   localparam logic [10:0] REACH     = 11'(RADIUS + SPEED);
   localparam logic [10:0] RIGHT_LIM = 11'(H_ACTIVE - 1);
   localparam logic [10:0] BOTTOM_LIM = 11'(V_ACTIVE - 1);
   localparam logic [10:0] PAD_TOP   = 11'(PADDLE_Y);
   localparam logic [10:0] PAD_W     = 11'(PADDLE_W);
   localparam logic [9:0]  X_MAX     = 10'(H_ACTIVE - 1 - RADIUS);
   localparam logic [9:0]  Y_PAD     = 10'(PADDLE_Y - RADIUS);
   localparam logic [9:0]  RAD       = 10'(RADIUS);
   localparam logic [9:0]  SPD       = 10'(SPEED);
   localparam logic [9:0]  SX        = 10'(START_X);
   localparam logic [9:0]  SY        = 10'(START_Y);
   localparam logic [9:0]  VS_LINE   = 10'(V_ACTIVE);

   state_e     state_q, state_d;
   logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic       frame_q, fired_q;
   logic       running_q;
   logic       bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
   logic       paddle_hit_q, paddle_hit_d, missed_q, missed_d;
   logic       at_vs_s;
   logic [10:0] x_s, y_s, pad_s;

   assign at_vs_s = (pixelX == 10'd0) && (pixelY == VS_LINE);
   assign x_s     = {1'b0, ball_x_q};
   assign y_s     = {1'b0, ball_y_q};
   assign pad_s   = {1'b0, paddleX};

   // One frame pulse per blanking line; fired_q blocks repeats while pixelX/Y are held.
   always_ff @(posedge clock) begin
      if (reset) begin
         frame_q <= 1'b0;
         fired_q <= 1'b0;
      end else begin
         frame_q <= pTick && at_vs_s && !fired_q;
         fired_q <= at_vs_s && (fired_q || pTick);
      end
   end

   // Next-state, next-position and pulse decode for one motion update.
   always_comb begin
      state_d      = state_q;
      ball_x_d     = ball_x_q;
      ball_y_d     = ball_y_q;
      dir_x_d      = dir_x_q;
      dir_y_d      = dir_y_q;
      bounce_x_d   = 1'b0;
      bounce_y_d   = 1'b0;
      paddle_hit_d = 1'b0;
      missed_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
            else       state_d = IDLE;
         end
         RUN: begin
            if (frame_q) begin
               if (dir_x_q) begin
                  if ((x_s + REACH) >= RIGHT_LIM) begin
                     ball_x_d = X_MAX; dir_x_d = 1'b0; bounce_x_d = 1'b1;
                  end else begin
                     ball_x_d = ball_x_q + SPD;
                  end
               end else begin
                  if (x_s <= REACH) begin
                     ball_x_d = RAD; dir_x_d = 1'b1; bounce_x_d = 1'b1;
                  end else begin
                     ball_x_d = ball_x_q - SPD;
                  end
               end
               if (!dir_y_q) begin
                  if (y_s <= REACH) begin
                     ball_y_d = RAD; dir_y_d = 1'b1; bounce_y_d = 1'b1;
                  end else begin
                     ball_y_d = ball_y_q - SPD;
                  end
               end else if (((y_s + REACH) >= PAD_TOP) && (pad_s <= x_s) && (x_s < (pad_s + PAD_W))) begin
                  ball_y_d = Y_PAD; dir_y_d = 1'b0; bounce_y_d = 1'b1; paddle_hit_d = 1'b1;
               end else if ((y_s + REACH) >= BOTTOM_LIM) begin
                  // A miss overrides whatever the X axis decided in this update.
                  missed_d   = 1'b1;
                  bounce_x_d = 1'b0;
                  ball_x_d   = SX;
                  ball_y_d   = SY;
                  dir_x_d    = 1'b1;
                  dir_y_d    = 1'b0;
                  state_d    = IDLE;
               end else begin
                  ball_y_d = ball_y_q + SPD;
               end
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Motion FSM state, position, direction and registered pulse outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         ball_x_q     <= SX;
         ball_y_q     <= SY;
         dir_x_q      <= 1'b1;
         dir_y_q      <= 1'b0;
         running_q    <= 1'b0;
         bounce_x_q   <= 1'b0;
         bounce_y_q   <= 1'b0;
         paddle_hit_q <= 1'b0;
         missed_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ball_x_q     <= ball_x_d;
         ball_y_q     <= ball_y_d;
         dir_x_q      <= dir_x_d;
         dir_y_q      <= dir_y_d;
         running_q    <= (state_d == RUN);
         bounce_x_q   <= bounce_x_d;
         bounce_y_q   <= bounce_y_d;
         paddle_hit_q <= paddle_hit_d;
         missed_q     <= missed_d;
      end
   end

   assign ballX     = ball_x_q;
   assign ballY     = ball_y_q;
   assign running   = running_q;
   assign frameTick = frame_q;
   assign bounceX   = bounce_x_q;
   assign bounceY   = bounce_y_q;
   assign paddleHit = paddle_hit_q;
   assign missed    = missed_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: short synthetic frames, hand-computed trajectories.
module tb_ball_motion_ctrl;

   logic       clock = 1'b0;
   logic       reset, pTick, start;
   logic [9:0] pixelX, pixelY, paddleX;
   logic [9:0] ballX, ballY, ballX3, ballY3;
   logic       running, frameTick, bounceX, bounceY, paddleHit, missed;
   logic       running3, frameTick3, bounceX3, bounceY3, paddleHit3, missed3;

   int checks = 0;
   int errors = 0;
   int ft_cnt, bx_cnt, by_cnt, ph_cnt, ms_cnt;
   int bx3_cnt, by3_cnt, corner3_cnt, other3_cnt;

   always #5 clock = ~clock;

   ball_motion_ctrl dut (
      .clock(clock), .reset(reset), .pTick(pTick), .pixelX(pixelX), .pixelY(pixelY),
      .start(start), .paddleX(paddleX), .ballX(ballX), .ballY(ballY), .running(running),
      .frameTick(frameTick), .bounceX(bounceX), .bounceY(bounceY), .paddleHit(paddleHit),
      .missed(missed)
   );

   ball_motion_ctrl #(.START_X(627), .START_Y(12)) dut3 (
      .clock(clock), .reset(reset), .pTick(pTick), .pixelX(pixelX), .pixelY(pixelY),
      .start(start), .paddleX(paddleX), .ballX(ballX3), .ballY(ballY3), .running(running3),
      .frameTick(frameTick3), .bounceX(bounceX3), .bounceY(bounceY3), .paddleHit(paddleHit3),
      .missed(missed3)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      ft_cnt += int'(frameTick);
      bx_cnt += int'(bounceX);
      by_cnt += int'(bounceY);
      ph_cnt += int'(paddleHit);
      ms_cnt += int'(missed);
      bx3_cnt += int'(bounceX3);
      by3_cnt += int'(bounceY3);
      corner3_cnt += int'(bounceX3 && bounceY3);
      other3_cnt += int'(paddleHit3) + int'(missed3);
   endtask

   // Blanking line held 4 clocks with pTick high throughout, then 4 clocks of active video.
   task automatic run_frame();
      ft_cnt = 0; bx_cnt = 0; by_cnt = 0; ph_cnt = 0; ms_cnt = 0;
      bx3_cnt = 0; by3_cnt = 0; corner3_cnt = 0; other3_cnt = 0;
      pTick = 1'b1; pixelX = 10'd0; pixelY = 10'd480;
      repeat (4) begin tick(); sample(); end
      pixelX = 10'd5; pixelY = 10'd0;
      repeat (4) begin tick(); sample(); end
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic test_reset();
      int total;
      do_reset();
      checks++; if (ballX !== 10'd320) begin errors++; $display("FAIL rst_ballX got=%0d exp=320", ballX); end
      checks++; if (ballY !== 10'd240) begin errors++; $display("FAIL rst_ballY got=%0d exp=240", ballY); end
      checks++; if ({running, frameTick, bounceX, bounceY, paddleHit, missed} !== 6'b0) begin
         errors++; $display("FAIL rst_flags got=%b exp=000000", {running, frameTick, bounceX, bounceY, paddleHit, missed}); end
      total = 0;
      for (int f = 0; f < 3; f++) begin
         run_frame();
         total += ft_cnt;
         checks++; if (ft_cnt != 1) begin errors++; $display("FAIL t1_frametick_width frame=%0d got=%0d exp=1", f, ft_cnt); end
      end
      checks++; if (total != 3) begin errors++; $display("FAIL t1_frametick_total got=%0d exp=3", total); end
      checks++; if (ballX !== 10'd320 || ballY !== 10'd240 || running !== 1'b0) begin
         errors++; $display("FAIL t1_idle_frozen got=%0d,%0d,%b exp=320,240,0", ballX, ballY, running); end
   endtask

   task automatic test_launch();
      pulse_start();
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL t2_running_on_start got=%b exp=1", running); end
      checks++; if (ballX !== 10'd320) begin errors++; $display("FAIL t2_no_move_before_frame got=%0d exp=320", ballX); end
      run_frame();
      checks++; if (ballX !== 10'd322 || ballY !== 10'd238) begin
         errors++; $display("FAIL t2_first_move got=%0d,%0d exp=322,238", ballX, ballY); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL t2_running got=%b exp=1", running); end
      checks++; if (bx_cnt + by_cnt + ph_cnt + ms_cnt != 0) begin
         errors++; $display("FAIL t2_no_pulses got=%0d exp=0", bx_cnt + by_cnt + ph_cnt + ms_cnt); end
   endtask

   task automatic test_corner();
      do_reset();
      pulse_start();
      run_frame();
      checks++; if (ballX3 !== 10'd629 || ballY3 !== 10'd10) begin
         errors++; $display("FAIL t3_corner_pos got=%0d,%0d exp=629,10", ballX3, ballY3); end
      checks++; if (corner3_cnt != 1 || bx3_cnt != 1 || by3_cnt != 1 || other3_cnt != 0) begin
         errors++; $display("FAIL t3_corner_pulses got=both%0d/x%0d/y%0d/o%0d exp=1/1/1/0", corner3_cnt, bx3_cnt, by3_cnt, other3_cnt); end
      checks++; if (running3 !== 1'b1 || frameTick3 !== 1'b0) begin
         errors++; $display("FAIL t3_running got=%b,%b exp=1,0", running3, frameTick3); end
      run_frame();
      checks++; if (ballX3 !== 10'd627 || ballY3 !== 10'd12) begin
         errors++; $display("FAIL t3_after_corner got=%0d,%0d exp=627,12", ballX3, ballY3); end
      checks++; if (bx3_cnt + by3_cnt != 0) begin errors++; $display("FAIL t3_no_repeat got=%0d exp=0", bx3_cnt + by3_cnt); end
   endtask

   task automatic test_paddle();
      int hit_frame;
      int by_at_hit;
      do_reset();
      paddleX = 10'd280;
      pulse_start();
      hit_frame = 0; by_at_hit = 0;
      for (int f = 1; f <= 400 && hit_frame == 0; f++) begin
         run_frame();
         if (ph_cnt != 0) begin hit_frame = f; by_at_hit = by_cnt; end
      end
      checks++; if (hit_frame != 330) begin errors++; $display("FAIL t4_hit_frame got=%0d exp=330", hit_frame); end
      checks++; if (ballY !== 10'd440 || ballX !== 10'd279) begin
         errors++; $display("FAIL t4_hit_pos got=%0d,%0d exp=279,440", ballX, ballY); end
      checks++; if (ph_cnt != 1 || by_at_hit != 1 || ms_cnt != 0) begin
         errors++; $display("FAIL t4_hit_pulses got=ph%0d/y%0d/m%0d exp=1/1/0", ph_cnt, by_at_hit, ms_cnt); end
      run_frame();
      checks++; if (ballY !== 10'd438 || ballX !== 10'd277) begin
         errors++; $display("FAIL t4_moves_up got=%0d,%0d exp=277,438", ballX, ballY); end
   endtask

   task automatic test_miss();
      int miss_frame;
      int bx_at_miss;
      do_reset();
      paddleX = 10'd0;
      pulse_start();
      miss_frame = 0; bx_at_miss = 0;
      for (int f = 1; f <= 400 && miss_frame == 0; f++) begin
         run_frame();
         checks++; if (ph_cnt != 0) begin errors++; $display("FAIL t5_spurious_hit frame=%0d got=%0d exp=0", f, ph_cnt); end
         if (ms_cnt != 0) begin miss_frame = f; bx_at_miss = bx_cnt; end
      end
      checks++; if (miss_frame != 345) begin errors++; $display("FAIL t5_miss_frame got=%0d exp=345", miss_frame); end
      checks++; if (ms_cnt != 1 || bx_at_miss != 0 || by_cnt != 0) begin
         errors++; $display("FAIL t5_miss_pulses got=m%0d/x%0d/y%0d exp=1/0/0", ms_cnt, bx_at_miss, by_cnt); end
      checks++; if (ballX !== 10'd320 || ballY !== 10'd240 || running !== 1'b0) begin
         errors++; $display("FAIL t5_respawn got=%0d,%0d,%b exp=320,240,0", ballX, ballY, running); end
      repeat (3) run_frame();
      checks++; if (ballX !== 10'd320 || ballY !== 10'd240 || running !== 1'b0 || ms_cnt != 0) begin
         errors++; $display("FAIL t5_idle_after_miss got=%0d,%0d,%b,%0d exp=320,240,0,0", ballX, ballY, running, ms_cnt); end
   endtask

   task automatic test_start_held_and_reset();
      do_reset();
      paddleX = 10'd280;
      start = 1'b1;
      repeat (3) run_frame();
      checks++; if (ballX !== 10'd326 || ballY !== 10'd234 || running !== 1'b1) begin
         errors++; $display("FAIL t6_start_held got=%0d,%0d,%b exp=326,234,1", ballX, ballY, running); end
      reset = 1'b1;
      tick();
      checks++; if (ballX !== 10'd320 || ballY !== 10'd240 || running !== 1'b0) begin
         errors++; $display("FAIL t6_reset_mid_run got=%0d,%0d,%b exp=320,240,0", ballX, ballY, running); end
      reset = 1'b0; start = 1'b0;
      run_frame();
      checks++; if (ballX !== 10'd320 || ballY !== 10'd240 || running !== 1'b0) begin
         errors++; $display("FAIL t6_idle_after_reset got=%0d,%0d,%b exp=320,240,0", ballX, ballY, running); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; pTick = 1'b0;
      pixelX = 10'd5; pixelY = 10'd0; paddleX = 10'd280;
      test_reset();
      test_launch();
      test_corner();
      test_paddle();
      test_miss();
      test_start_held_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
